// File: rtl/regression_monitor.sv
// Result monitor for CPU regression runs: snoops the write bus into a set of
// check slots, detects the JMP-* halt loop or a cycle timeout, and latches a verdict.
module regression_monitor #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int NCHK    = 4,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (NCHK > 1) ? $clog2(NCHK) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              sync,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [NCHK-1:0]   seen,
  output logic [NCHK-1:0]   fail_mask,
  output logic [CNT_W-1:0]  cycles
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [NCHK-1:0]   slot_en;
  logic [ADDR_W-1:0] slot_addr [NCHK];
  logic [DATA_W-1:0] slot_exp  [NCHK];
  logic [DATA_W-1:0] cap       [NCHK];
  logic [DATA_W-1:0] cap_nx    [NCHK];
  logic [NCHK-1:0]   seen_nx;
  logic [NCHK-1:0]   fail_nx;
  logic [NCHK-1:0]   cfg_hit;
  logic [NCHK-1:0]   wr_hit;
  logic [ADDR_W-1:0] last_pc;
  logic              last_pc_valid;
  logic [CNT_W-1:0]  cycles_nx;
  logic              running;
  logic              cfg_ok;
  logic              start_ok;
  logic              halt;
  logic              expire;
  logic              finish;

  assign running  = (state == S_RUN);
  assign cfg_ok   = cfg_we && !running;
  assign start_ok = start && !running;

  // Halt has priority: a repeated fetch in the last allowed cycle is a clean finish.
  assign halt   = running && sync && last_pc_valid && (pc == last_pc);
  assign expire = running && !halt && (cycles == LAST_CYCLE);
  assign finish = halt || expire;

  assign cycles_nx = (&cycles) ? cycles : cycles + CNT_W'(1);

  // The verdict is built from the post-write view so a write in the
  // terminating cycle counts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default is how latches get inferred.
    seen_nx = seen;
    wr_hit  = '0;
    cfg_hit = '0;
    fail_nx = '0;
    for (int i = 0; i < NCHK; i++) begin
      cfg_hit[i] = cfg_ok && (cfg_idx == IDX_W'(i));
      wr_hit[i]  = mem_we && slot_en[i] && (mem_addr == slot_addr[i]);
      cap_nx[i]  = wr_hit[i] ? mem_wdata : cap[i];
      if (wr_hit[i]) begin
        seen_nx[i] = 1'b1;
      end
      fail_nx[i] = slot_en[i] && (!seen_nx[i] || (cap_nx[i] != slot_exp[i]));
    end
  end

  // Control and visible status: everything here must come up known after reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state         <= S_IDLE;
      slot_en       <= '0;
      seen          <= '0;
      fail_mask     <= '0;
      cycles        <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      last_pc_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NCHK; i++) begin
        if (cfg_hit[i]) begin
          slot_en[i] <= cfg_en;
        end
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_RUN;
            seen          <= '0;
            fail_mask     <= '0;
            cycles        <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            last_pc_valid <= 1'b0;
          end
        end
        S_RUN: begin
          cycles <= cycles_nx;
          seen   <= seen_nx;
          if (sync && !halt) begin
            last_pc_valid <= 1'b1;
          end
          if (finish) begin
            state     <= S_DONE;
            done      <= 1'b1;
            timeout   <= expire;
            fail_mask <= fail_nx;
            pass      <= !expire && (fail_nx == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Slot payload and the PC tracker are only meaningful behind slot_en,
  // seen and last_pc_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately left out of reset; their valid
    // qualifiers are reset instead, which keeps the arrays plain RAM-like flops.
    for (int i = 0; i < NCHK; i++) begin
      if (cfg_hit[i]) begin
        slot_addr[i] <= cfg_addr;
        slot_exp[i]  <= cfg_data;
      end
      if (start_ok) begin
        cap[i] <= '0;
      end else if (running) begin
        cap[i] <= cap_nx[i];
      end
    end
    if (running && sync && !halt) begin
      last_pc <= pc;
    end
  end

endmodule

// File: tb/tb_regression_monitor.sv
// Directed bench for regression_monitor: a per-address write-history model
// predicts every output each cycle; literal checks pin key scenario results.
module tb_regression_monitor;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int NCHK    = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_idx = '0;
  logic              cfg_en = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic              start = 1'b0;
  logic              sync = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [NCHK-1:0]   seen;
  logic [NCHK-1:0]   fail_mask;
  logic [CNT_W-1:0]  cycles;

  int checks = 0;
  int errors = 0;

  regression_monitor #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCHK(NCHK), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .sync(sync), .pc(pc),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .pass(pass), .timeout(timeout),
    .seen(seen), .fail_mask(fail_mask), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: configuration table plus "last value written to each address this run".
  bit                m_armed = 0;
  bit                m_run = 0;
  logic [NCHK-1:0]   m_en = '0;
  logic [ADDR_W-1:0] m_addr [NCHK];
  logic [DATA_W-1:0] m_exp  [NCHK];
  logic [DATA_W-1:0] wr_last [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] m_last_pc = '0;
  bit                m_pc_valid = 0;
  logic              e_done = 0, e_pass = 0, e_timeout = 0;
  logic [NCHK-1:0]   e_seen = '0, e_fail = '0;
  logic [CNT_W-1:0]  e_cycles = '0;

  task automatic model_step();
    bit halt_now, to_now;
    if (reset) begin
      m_armed = 1; m_run = 0; m_en = '0; m_pc_valid = 0;
      wr_last.delete();
      e_done = 0; e_pass = 0; e_timeout = 0; e_seen = '0; e_fail = '0; e_cycles = '0;
    end else if (!m_run) begin
      if (cfg_we && int'(cfg_idx) < NCHK) begin
        m_en[cfg_idx] = cfg_en;
        m_addr[cfg_idx] = cfg_addr;
        m_exp[cfg_idx] = cfg_data;
      end
      if (start) begin
        m_run = 1; m_pc_valid = 0;
        wr_last.delete();
        e_done = 0; e_pass = 0; e_timeout = 0; e_seen = '0; e_fail = '0; e_cycles = '0;
      end
    end else begin
      if (e_cycles != {CNT_W{1'b1}}) e_cycles = e_cycles + 1;
      if (mem_we) wr_last[mem_addr] = mem_wdata;
      for (int i = 0; i < NCHK; i++) e_seen[i] = m_en[i] && wr_last.exists(m_addr[i]);
      halt_now = sync && m_pc_valid && (pc == m_last_pc);
      if (sync && !halt_now) begin
        m_last_pc = pc;
        m_pc_valid = 1;
      end
      to_now = !halt_now && (int'(e_cycles) == TIMEOUT);
      if (halt_now || to_now) begin
        m_run = 0;
        e_fail = '0;
        for (int i = 0; i < NCHK; i++) begin
          if (m_en[i] && (!wr_last.exists(m_addr[i]) || wr_last[m_addr[i]] != m_exp[i]))
            e_fail[i] = 1'b1;
        end
        e_done = 1;
        e_timeout = to_now;
        e_pass = !to_now && (e_fail == '0);
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_armed) begin
      check("cmp_done", 32'(done), 32'(e_done));
      check("cmp_pass", 32'(pass), 32'(e_pass));
      check("cmp_timeout", 32'(timeout), 32'(e_timeout));
      check("cmp_seen", 32'(seen), 32'(e_seen));
      check("cmp_fail_mask", 32'(fail_mask), 32'(e_fail));
      check("cmp_cycles", 32'(cycles), 32'(e_cycles));
    end
  end

  task automatic clr();
    reset = 0; cfg_we = 0; cfg_idx = '0; cfg_en = 0; cfg_addr = '0; cfg_data = '0;
    start = 0; sync = 0; pc = '0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
  endtask

  task automatic nop();
    @(negedge clk); clr();
  endtask

  task automatic do_reset();
    @(negedge clk); clr(); reset = 1;
  endtask

  task automatic cfg(input int idx, input logic en, input logic [15:0] a,
                     input logic [7:0] d, input logic st);
    @(negedge clk); clr();
    cfg_we = 1; cfg_idx = 2'(idx); cfg_en = en; cfg_addr = a; cfg_data = d; start = st;
  endtask

  task automatic go();
    @(negedge clk); clr(); start = 1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); clr(); mem_we = 1; mem_addr = a; mem_wdata = d;
  endtask

  task automatic fetch(input logic [15:0] p);
    @(negedge clk); clr(); sync = 1; pc = p;
  endtask

  task automatic fetch_wr(input logic [15:0] p, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); clr(); sync = 1; pc = p; mem_we = 1; mem_addr = a; mem_wdata = d;
  endtask

  initial begin
    do_reset();
    nop();
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_seen", 32'(seen), 0);
    check("rst_cycles", 32'(cycles), 0);

    // Single slot, correct final value after an earlier wrong one.
    cfg(0, 1, 16'h0042, 8'hA5, 0);
    go();
    wr(16'h0042, 8'h00);
    wr(16'h0042, 8'hA5);
    check("t1_seen_run", 32'(seen), 32'h1);
    check("t1_done_run", 32'(done), 0);
    fetch(16'hF010);
    fetch(16'hF010);
    nop();
    check("t1_done", 32'(done), 1);
    check("t1_pass", 32'(pass), 1);
    check("t1_fail", 32'(fail_mask), 0);
    check("t1_seen", 32'(seen), 32'h1);
    check("t1_cycles", 32'(cycles), 4);

    // Last write wins, and it is wrong.
    go();
    wr(16'h0042, 8'hA5);
    wr(16'h0042, 8'h5A);
    fetch(16'h0100);
    fetch(16'h0100);
    nop();
    check("t2_pass", 32'(pass), 0);
    check("t2_fail", 32'(fail_mask), 32'h1);

    // Two slots watching one address with different expectations.
    cfg(0, 1, 16'h0042, 8'h5A, 0);
    cfg(1, 1, 16'h0042, 8'hA5, 0);
    go();
    wr(16'h0042, 8'hA5);
    wr(16'h0042, 8'h5A);
    fetch(16'h0200);
    fetch(16'h0200);
    nop();
    check("t2b_fail", 32'(fail_mask), 32'h2);
    check("t2b_seen", 32'(seen), 32'h3);

    // Enabled slot never written.
    cfg(0, 1, 16'h0042, 8'hA5, 0);
    cfg(1, 1, 16'h0043, 8'h11, 0);
    go();
    wr(16'h0042, 8'hA5);
    fetch(16'h0300);
    fetch(16'h0300);
    nop();
    check("t3_seen", 32'(seen), 32'h1);
    check("t3_fail", 32'(fail_mask), 32'h2);
    check("t3_pass", 32'(pass), 0);

    // Timeout with ever-changing PCs.
    cfg(1, 0, 16'h0000, 8'h00, 0);
    go();
    for (int i = 0; i < TIMEOUT; i++) fetch(16'h1000 + 16'(i));
    check("t4_done_early", 32'(done), 0);
    nop();
    check("t4_done", 32'(done), 1);
    check("t4_timeout", 32'(timeout), 1);
    check("t4_pass", 32'(pass), 0);
    check("t4_cycles", 32'(cycles), 64);

    // Halt lands on the last allowed cycle together with the only write.
    go();
    for (int i = 0; i < TIMEOUT - 1; i++) fetch(16'h2000 + 16'(i));
    fetch_wr(16'h2000 + 16'(TIMEOUT - 2), 16'h0042, 8'hA5);
    nop();
    check("t5_timeout", 32'(timeout), 0);
    check("t5_pass", 32'(pass), 1);
    check("t5_seen", 32'(seen), 32'h1);
    check("t5_cycles", 32'(cycles), 64);

    // Reset mid-run clears everything including the slot table.
    go();
    wr(16'h0042, 8'hA5);
    fetch(16'h0010);
    do_reset();
    nop();
    check("t6_done", 32'(done), 0);
    check("t6_seen", 32'(seen), 0);
    check("t6_cycles", 32'(cycles), 0);
    go();
    fetch(16'h0020);
    fetch(16'h0020);
    nop();
    check("t6_empty_pass", 32'(pass), 1);
    check("t6_empty_fail", 32'(fail_mask), 0);

    // Config and start together; config write during the run is ignored.
    cfg(0, 1, 16'h0050, 8'h77, 1);
    wr(16'h0050, 8'h77);
    cfg(0, 1, 16'h0060, 8'h00, 0);
    fetch(16'h0030);
    fetch(16'h0030);
    nop();
    check("t7_pass", 32'(pass), 1);
    check("t7_cycles", 32'(cycles), 4);

    // Restart from DONE clears run state; start inside the run is ignored.
    go();
    wr(16'h0050, 8'h11);
    check("t8_seen_clr", 32'(seen), 0);
    check("t8_cycles_clr", 32'(cycles), 0);
    go();
    fetch(16'h0040);
    fetch(16'h0040);
    nop();
    check("t8_pass", 32'(pass), 0);
    check("t8_fail", 32'(fail_mask), 32'h1);
    check("t8_cycles", 32'(cycles), 4);

    nop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
